// File: rtl/alu_arbiter.sv
// alu_arbiter
// Two-requester round-robin arbiter and sequencer for a shared 64-bit
// combinational ALU. One operation is in flight at a time: the winning
// request is registered onto the ALU inputs, the result is captured after
// ALU_SETTLE cycles, then returned to the owning requester.
//
// Ports:
//   clk, reset_n                      clock (rising edge), async active-low reset
//   reqX_valid / reqX_ready           request handshake, X = 0, 1
//   reqX_cntrl, reqX_shiftdir,
//   reqX_a, reqX_b                    operation payload
//   respX_valid / respX_ready         response handshake, X = 0, 1
//   resp_result, resp_flags           captured result and {N, Z, V, C}
//   alu_a, alu_b, alu_cntrl,
//   alu_shiftdir                      registered ALU operands
//   alu_result, alu_negative,
//   alu_zero, alu_overflow,
//   alu_carry_out                     ALU outputs
//   busy                              operation in flight (SETTLE or RESP)
module alu_arbiter #(
    parameter int unsigned ALU_SETTLE = 2  // legal range 1..15
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_cntrl,
    input  logic        req0_shiftdir,
    input  logic [63:0] req0_a,
    input  logic [63:0] req0_b,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_cntrl,
    input  logic        req1_shiftdir,
    input  logic [63:0] req1_a,
    input  logic [63:0] req1_b,

    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [63:0] resp_result,
    output logic [3:0]  resp_flags,

    output logic [63:0] alu_a,
    output logic [63:0] alu_b,
    output logic [2:0]  alu_cntrl,
    output logic        alu_shiftdir,
    input  logic [63:0] alu_result,
    input  logic        alu_negative,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    input  logic        alu_carry_out,

    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    state_t     state, state_nxt;
    logic       grant;       // requester that would win in IDLE this cycle
    logic       owner;       // requester of the operation in flight
    logic       last_grant;  // requester served most recently
    logic [3:0] settle_cnt;
    logic       handshake;
    logic       resp_done;
    logic       capture;
    logic       is_arith;

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        grant = ~last_grant;
        unique case ({req1_valid, req0_valid})
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            default: grant = ~last_grant;  // tie (or nobody): the other side wins
        endcase
    end

    assign req0_ready = (state == S_IDLE) && req0_valid && !grant;
    assign req1_ready = (state == S_IDLE) && req1_valid &&  grant;
    assign handshake  = req0_ready || req1_ready;

    assign resp0_valid = (state == S_RESP) && !owner;
    assign resp1_valid = (state == S_RESP) &&  owner;
    assign resp_done   = (state == S_RESP) && (owner ? resp1_ready : resp0_ready);

    assign capture  = (state == S_SETTLE) && (settle_cnt == 4'd0);
    assign is_arith = (alu_cntrl == OP_ADD) || (alu_cntrl == OP_SUB);
    assign busy     = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (handshake) state_nxt = S_SETTLE;
            S_SETTLE: if (capture)   state_nxt = S_RESP;
            S_RESP:   if (resp_done) state_nxt = S_IDLE;
            default:                 state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand registers, ownership and round-robin history.
    // NOTE: every register here, including the wide datapath ones, is reset:
    // an aborted operation must leave no stale operands or results visible.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_a        <= '0;
            alu_b        <= '0;
            alu_cntrl    <= '0;
            alu_shiftdir <= 1'b0;
            owner        <= 1'b0;
            last_grant   <= 1'b1;  // requester 0 wins the first tie
        end else begin
            if (handshake) begin
                alu_a        <= grant ? req1_a        : req0_a;
                alu_b        <= grant ? req1_b        : req0_b;
                alu_cntrl    <= grant ? req1_cntrl    : req0_cntrl;
                alu_shiftdir <= grant ? req1_shiftdir : req0_shiftdir;
                owner        <= grant;
            end
            if (resp_done) begin
                last_grant <= owner;
            end
        end
    end

    // Settle counter and result capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            settle_cnt  <= '0;
            resp_result <= '0;
            resp_flags  <= '0;
        end else begin
            if (handshake) begin
                settle_cnt <= 4'(ALU_SETTLE - 1);
            end else if ((state == S_SETTLE) && (settle_cnt != 4'd0)) begin
                settle_cnt <= settle_cnt - 4'd1;
            end
            if (capture) begin
                resp_result <= alu_result;
                // Overflow and carry only mean something for add/sub.
                resp_flags  <= {alu_negative, alu_zero,
                                alu_overflow  & is_arith,
                                alu_carry_out & is_arith};
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Scoreboard bench for alu_arbiter: a behavioural ALU drives the ALU inputs,
// expected responses are queued at each request handshake and compared when
// the response handshake completes.
module tb_alu_arbiter;

    localparam int SETTLE = 2;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_SHFT = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_cntrl = '0, req1_cntrl = '0;
    logic        req0_shiftdir = 1'b0, req1_shiftdir = 1'b0;
    logic [63:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        resp0_valid, resp1_valid;
    logic        resp0_ready = 1'b1, resp1_ready = 1'b1;
    logic [63:0] resp_result;
    logic [3:0]  resp_flags;
    logic [63:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_cntrl;
    logic        alu_shiftdir;
    logic        alu_negative, alu_zero, alu_overflow, alu_carry_out;
    logic        busy;
    logic        force_vc = 1'b0;  // forces the ALU's V and C outputs high

    always #5 clk = ~clk;

    alu_arbiter #(.ALU_SETTLE(SETTLE)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cntrl(req0_cntrl),
        .req0_shiftdir(req0_shiftdir), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cntrl(req1_cntrl),
        .req1_shiftdir(req1_shiftdir), .req1_a(req1_a), .req1_b(req1_b),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_result(resp_result), .resp_flags(resp_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cntrl(alu_cntrl), .alu_shiftdir(alu_shiftdir),
        .alu_result(alu_result), .alu_negative(alu_negative), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
        .busy(busy)
    );

    // ---------------- behavioural ALU ----------------
    typedef struct packed {
        logic        n, z, v, c;
        logic [63:0] r;
    } alu_out_t;

    function automatic alu_out_t alu_ref(input logic [2:0] op, input logic [63:0] a,
                                         input logic [63:0] b, input logic dir);
        alu_out_t   o;
        logic [64:0] s;
        o = '0;
        s = '0;
        case (op)
            OP_PASS: o.r = b;
            OP_SHFT: o.r = dir ? (a >> b[5:0]) : (a << b[5:0]);
            OP_ADD: begin
                s   = {1'b0, a} + {1'b0, b};
                o.r = s[63:0];
                o.c = s[64];
                o.v = (a[63] == b[63]) && (o.r[63] != a[63]);
            end
            OP_SUB: begin
                s   = {1'b0, a} + {1'b0, ~b} + 65'd1;
                o.r = s[63:0];
                o.c = s[64];
                o.v = (a[63] != b[63]) && (o.r[63] != a[63]);
            end
            OP_AND:  o.r = a & b;
            OP_OR:   o.r = a | b;
            OP_XOR:  o.r = a ^ b;
            default: o.r = a * b;
        endcase
        o.n = o.r[63];
        o.z = (o.r == 64'd0);
        return o;
    endfunction

    alu_out_t alu_o;
    always_comb begin
        alu_o         = alu_ref(alu_cntrl, alu_a, alu_b, alu_shiftdir);
        alu_result    = alu_o.r;
        alu_negative  = alu_o.n;
        alu_zero      = alu_o.z;
        alu_overflow  = alu_o.v | force_vc;
        alu_carry_out = alu_o.c | force_vc;
    end

    // ---------------- checking ----------------
    int checks = 0;
    int failures = 0;
    int cycle = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cycle <= cycle + 1;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        owner;
        logic [63:0] result;
        logic [3:0]  flags;
        int          hs_cycle;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    logic resp_seen = 1'b0;
    int   hs_cycle[2];
    int   done_cycle[2];

    function automatic exp_t make_exp(input logic id, input logic [2:0] op, input logic [63:0] a,
                                      input logic [63:0] b, input logic dir, input int hs);
        exp_t     e;
        alu_out_t o;
        logic     arith;
        o          = alu_ref(op, a, b, dir);
        arith      = (op == OP_ADD) || (op == OP_SUB);
        e.owner    = id;
        e.result   = o.r;
        e.flags    = {o.n, o.z, (o.v | force_vc) & arith, (o.c | force_vc) & arith};
        e.hs_cycle = hs;
        return e;
    endfunction

    // Outputs are sampled on the falling edge; a valid&ready seen here
    // completes at the following rising edge (cycle + 1).
    always @(negedge clk) begin
        if (reset_n) begin
            check("busy", busy, sb.size() != 0);
            if (resp0_valid && resp1_valid) check("resp_both_valid", 2, 1);
            if (resp0_valid || resp1_valid) begin
                if (sb.size() == 0) begin
                    check("resp_unexpected", sb.size(), 1);
                end else begin
                    if (!resp_seen) begin
                        check("latency", cycle - sb[0].hs_cycle, SETTLE);
                        resp_seen = 1'b1;
                    end
                    if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
                        check("resp_owner", resp1_valid, sb[0].owner);
                        check("resp_result", resp_result, sb[0].result);
                        check("resp_flags", resp_flags, sb[0].flags);
                        done_cycle[sb[0].owner] = cycle + 1;
                        void'(sb.pop_front());
                        resp_seen = 1'b0;
                    end
                end
            end
            if (req0_ready && req1_ready) check("ready_both", 2, 1);
            if (req0_valid && req0_ready) begin
                sb.push_back(make_exp(1'b0, req0_cntrl, req0_a, req0_b, req0_shiftdir, cycle + 1));
                grant_log.push_back(0);
                hs_cycle[0] = cycle + 1;
            end else if (req1_valid && req1_ready) begin
                sb.push_back(make_exp(1'b1, req1_cntrl, req1_a, req1_b, req1_shiftdir, cycle + 1));
                grant_log.push_back(1);
                hs_cycle[1] = cycle + 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int id, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic dir);
        logic got;
        got = 1'b0;
        @(posedge clk); #1;
        if (id == 0) begin
            req0_cntrl = op; req0_a = a; req0_b = b; req0_shiftdir = dir; req0_valid = 1'b1;
        end else begin
            req1_cntrl = op; req1_a = a; req1_b = b; req1_shiftdir = dir; req1_valid = 1'b1;
        end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((id == 0) ? req0_ready : req1_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("send_timeout", got, 1);
        @(posedge clk); #1;
        if (id == 0) req0_valid = 1'b0;
        else         req1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("idle_timeout", done, 1);
    endtask

    task automatic check_log(input string tag, input int exp0, input int exp1,
                             input int exp2, input int exp3, input int n);
        int e[4];
        e = '{exp0, exp1, exp2, exp3};
        check({tag, "_len"}, grant_log.size(), n);
        for (int i = 0; i < n && i < grant_log.size(); i++)
            check(tag, grant_log[i], e[i]);
        grant_log.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_alu_a"}, alu_a, 0);
        check({tag, "_alu_b"}, alu_b, 0);
        check({tag, "_alu_cntrl"}, alu_cntrl, 0);
        check({tag, "_alu_dir"}, alu_shiftdir, 0);
        check({tag, "_result"}, resp_result, 0);
        check({tag, "_flags"}, resp_flags, 0);
        check({tag, "_resp_v"}, {resp1_valid, resp0_valid}, 0);
        check({tag, "_ready"}, {req1_ready, req0_ready}, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // ---------------- test sequence ----------------
    logic [63:0] held;
    int          bp_done;

    initial begin
        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Contention from reset: requester 0 wins the first tie.
        fork
            send(0, OP_AND, 64'hF0, 64'h3C, 1'b0);
            send(1, OP_SUB, 64'd1, 64'd2, 1'b0);
        join
        wait_idle();
        check_log("first_tie", 0, 1, 0, 0, 2);
        check("sub_result", resp_result, 64'hffff_ffff_ffff_ffff);
        check("sub_flags", resp_flags, 4'b1000);

        // Sustained contention alternates.
        fork
            begin
                send(0, OP_OR, 64'h1, 64'h2, 1'b0);
                send(0, OP_MUL, 64'd6, 64'd7, 1'b0);
            end
            begin
                send(1, OP_PASS, 64'h5, 64'h1234, 1'b0);
                send(1, OP_XOR, 64'hFF, 64'h0F, 1'b0);
            end
        join
        wait_idle();
        check_log("alternate", 0, 1, 0, 1, 4);

        // ADD with signed overflow.
        send(0, OP_ADD, 64'h7fff_ffff_ffff_ffff, 64'd1, 1'b0);
        wait_idle();
        check("add_result", resp_result, 64'h8000_0000_0000_0000);
        check("add_flags", resp_flags, 4'b1010);
        check("alu_hold", alu_a, 64'h7fff_ffff_ffff_ffff);

        // Shifts use B[5:0].
        send(0, OP_SHFT, 64'd1, 64'h43, 1'b0);
        wait_idle();
        check("shl_result", resp_result, 64'd8);
        send(1, OP_SHFT, 64'h80, 64'h43, 1'b1);
        wait_idle();
        check("shr_result", resp_result, 64'h10);

        // Flag masking with V/C forced high by the ALU.
        force_vc = 1'b1;
        send(0, OP_XOR, 64'hA5, 64'h5A, 1'b0);
        wait_idle();
        check("xor_vc_masked", resp_flags[1:0], 2'b00);
        send(1, OP_SUB, 64'd5, 64'd3, 1'b0);
        wait_idle();
        check("sub_vc_pass", resp_flags[1:0], 2'b11);
        force_vc = 1'b0;

        // Backpressure on requester 0 blocks requester 1.
        resp0_ready = 1'b0;
        fork
            send(0, OP_ADD, 64'd10, 64'd20, 1'b0);
            send(1, OP_OR, 64'hF000, 64'h000F, 1'b0);
            begin
                for (int i = 0; i < 50 && !resp0_valid; i++) @(negedge clk);
                check("bp_resp0_valid", resp0_valid, 1);
                held = resp_result;
                check("bp_result", held, 64'd30);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("bp_stable", resp_result, held);
                    check("bp_req1_ready", req1_ready, 0);
                    check("bp_busy", busy, 1);
                end
                @(posedge clk); #1;
                resp0_ready = 1'b1;
            end
        join
        wait_idle();
        bp_done = done_cycle[0];
        check("bp_next_grant", hs_cycle[1] - bp_done, 1);

        // Reset during SETTLE discards the operation.
        send(0, OP_MUL, 64'd3, 64'd7, 1'b0);
        #3;
        check("pre_reset_busy", busy, 1);
        reset_n = 1'b0;
        sb.delete();
        resp_seen = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_reset_no_resp", {resp1_valid, resp0_valid}, 0);
        end
        send(1, OP_ADD, 64'd2, 64'd3, 1'b0);
        wait_idle();
        check("post_reset_result", resp_result, 64'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
